// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM pattern test generator.
package sdram_test_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sdram_test_lfsr.sv
// 16-bit pattern source for the SDRAM test; reseeded by load, advanced by step.
module sdram_test_lfsr
  import sdram_test_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  // load wins over step so a reseed on the last accepted write restarts the sequence cleanly
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = LFSR_SEED;
    else if (step) lfsr_d = lfsr_advance(lfsr_q);
  end

  // pattern register
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/sdram_test_gen.sv
// SDRAM write-then-readback test generator on an Avalon-style master port.
// Build option: define SDRAM_TEST_LFSR_EN for LFSR data, otherwise data = address[15:0].
//
// state   | meaning
// IDLE    | waiting for start after reset
// WR      | writing pattern word at address, held while waitrequest
// RD      | issuing read at address, held while waitrequest
// RD_WAIT | one read outstanding, waiting for readdatavalid
// DONE    | run finished, done/pass/err_cnt held until next start
module sdram_test_gen
  import sdram_test_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int WORDS  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] address,
  output logic              write,
  output logic              read,
  output logic [15:0]       writedata,
  input  logic              waitrequest,
  input  logic [15:0]       readdata,
  input  logic              readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic        wr_acc, rd_acc, rd_cmp, at_last, start_ok, mismatch;
  logic [15:0] data_word;

  assign wr_acc   = (state_q == WR) && !waitrequest;
  assign rd_acc   = (state_q == RD) && !waitrequest;
  assign rd_cmp   = (state_q == RD_WAIT) && readdatavalid;
  assign at_last  = (addr_q == LAST_ADDR);
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch = rd_cmp && (readdata != data_word);

`ifdef SDRAM_TEST_LFSR_EN
  // Reseed at run start and again after the last write so reads replay the write sequence
  sdram_test_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok || (wr_acc && at_last)),
    .step  (wr_acc || rd_cmp),
    .value (data_word)
  );
`else
  assign data_word = 16'(addr_q);
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WR;
      WR:      if (wr_acc && at_last) state_d = RD;
      RD:      if (rd_acc) state_d = RD_WAIT;
      RD_WAIT: if (rd_cmp) state_d = at_last ? DONE : RD;
      DONE:    if (start) state_d = WR;
      default: state_d = IDLE;
    endcase
  end

  // address walk, error accounting and result flags
  always_comb begin
    addr_d      = addr_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    if (start_ok) begin
      addr_d      = '0;
      err_cnt_d   = '0;
      first_err_d = '0;
      done_d      = 1'b0;
      pass_d      = 1'b0;
    end
    if (wr_acc) addr_d = at_last ? '0 : addr_q + ADDR_W'(1);
    if (rd_cmp) begin
      // err_cnt saturates, so zero reliably marks "no error seen yet"
      if (mismatch) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (err_cnt_q == 16'd0)    first_err_d = addr_q;
      end
      if (at_last) begin
        done_d = 1'b1;
        pass_d = (err_cnt_d == 16'd0);
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // bus and status outputs decoded from state
  always_comb begin
    write     = (state_q == WR);
    read      = (state_q == RD);
    busy      = (state_q == WR) || (state_q == RD) || (state_q == RD_WAIT);
    writedata = (state_q == WR) ? data_word : 16'h0000;
  end

  assign address        = addr_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule
